// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential double-dabble binary to packed-BCD converter.
//
// Feeds the 8-digit seven-segment scanner. One conversion runs at a time
// under a start/busy/done handshake. The converter shifts one input bit per
// cycle, so a result is ready BIN_W+1 edges after start is accepted.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   conversion request, honoured only in IDLE
//   bin_in   in   [BIN_W-1:0] unsigned operand, captured when start is accepted
//   busy     out  high while a conversion is in SHIFT or DONE
//   done     out  one-cycle pulse; bcd_out/blank/ovf are updated in that cycle
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, nibble 0 = least significant digit
//   blank    out  [DIGITS-1:0] leading-zero mask, bit 0 always 0
//   ovf      out  last operand exceeded 10^DIGITS-1 (bcd_out then shows all 9s)

// One BCD digit's add-3 correction, applied before each shift.
module bin2bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    // d <= 9 for a valid digit, so d+3 <= 12 and never leaves the nibble.
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);
    localparam int CW = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [BIN_W-1:0]       sr;
    logic [4*DIGITS-1:0]    acc, acc_adj, fin_bcd;
    logic [DIGITS-1:0]      fin_blank;
    logic [CW-1:0]          cnt;
    logic                   ovf_pend;

    // Per-digit add-3 correction on the accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin2bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy covers SHIFT and DONE; during the done pulse the FSM is back in
    // IDLE, so a held start is accepted on the very next edge.
    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Final result and leading-zero mask
    // ------------------------------------------------------------------
    assign fin_bcd = ovf_pend ? {DIGITS{4'h9}} : acc;

    // Walk down from the top digit; a digit is blank while it and all
    // higher digits are zero. Digit 0 always shows.
    always_comb begin
        logic run;
        fin_blank = '0;
        run       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run          = run & (fin_bcd[4*i +: 4] == 4'h0);
            fin_blank[i] = run;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= bin_in;
                        acc      <= '0;
                        cnt      <= CW'(BIN_W);
                        ovf_pend <= (64'(bin_in) > MAXV);
                    end
                end
                SHIFT: begin
                    // {bcd, bin} <<= 1 after the add-3 correction.
                    acc <= {acc_adj[4*DIGITS-2:0], sr[BIN_W-1]};
                    sr  <= {sr[BIN_W-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    bcd_out <= fin_bcd;
                    blank   <= fin_blank;
                    ovf     <= ovf_pend;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [26:0] bin_in;
    logic        busy, done, ovf;
    logic [31:0] bcd_out;
    logic [7:0]  blank;

    int tests = 0;
    int fails = 0;
    logic [31:0] prev_bcd;

    bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, blank by magnitude.
    task automatic model(input logic [26:0] v, output logic [31:0] b,
                         output logic [7:0] bl, output logic o);
        longint x, p;
        x  = longint'(v);
        b  = '0;
        bl = '0;
        o  = 1'b0;
        if (x > 99999999) begin
            b = 32'h99999999;
            o = 1'b1;
        end else begin
            p = 1;
            for (int i = 0; i < 8; i++) begin
                b[4*i +: 4] = 4'((x / p) % 10);
                if (i > 0 && x < p) bl[i] = 1'b1;
                p = p * 10;
            end
        end
    endtask

    // One conversion. Optionally pulses start with another operand at
    // cycle glitch (must be ignored). Checks latency, single pulse, results.
    task automatic conv(input logic [26:0] v, input int glitch, input string tag);
        logic [31:0] eb; logic [7:0] ebl; logic eo;
        int first, cnt;
        model(v, eb, ebl, eo);
        first = -1; cnt = 0;
        @(negedge clk);
        start = 1'b1; bin_in = v;
        @(negedge clk);          // E0 has passed
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int n = 1; n <= 32; n++) begin
            if (n == glitch + 1) start = 1'b0;
            @(negedge clk);
            if (n == glitch) begin
                start = 1'b1; bin_in = 27'd7;
            end
            if (n == 5) check({tag, "_hold"}, 64'(bcd_out), 64'(prev_bcd));
            if (done) begin
                cnt++;
                if (first < 0) begin
                    first = n;
                    check({tag, "_bcd"},   64'(bcd_out), 64'(eb));
                    check({tag, "_blank"}, 64'(blank),   64'(ebl));
                    check({tag, "_ovf"},   64'(ovf),     64'(eo));
                end
            end
        end
        start = 1'b0;
        check({tag, "_lat"},   64'(first), 64'd28);
        check({tag, "_npulse"}, 64'(cnt),  64'd1);
        check({tag, "_idle"},  64'(busy),  64'd0);
        prev_bcd = eb;
    endtask

    initial begin
        int pulses[$];
        int blow;
        logic [26:0] rv;
        logic [31:0] eb; logic [7:0] ebl; logic eo;

        rst_n = 1'b0; start = 1'b0; bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy),    64'd0);
        check("rst_done",  64'(done),    64'd0);
        check("rst_bcd",   64'(bcd_out), 64'd0);
        check("rst_blank", 64'(blank),   64'hFE);
        check("rst_ovf",   64'(ovf),     64'd0);
        rst_n = 1'b1;
        prev_bcd = 32'h0;

        conv(27'd0,         -1, "zero");
        conv(27'd12345678,  -1, "d12345678");
        conv(27'd905,       -1, "d905");
        conv(27'd100000000, -1, "ovf");
        conv(27'd99999999,  -1, "max");
        conv(27'd42,        10, "ignore");
        conv(27'd134217727, -1, "allones");
        conv(27'd10000000,  -1, "pow10");

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1; bin_in = 27'd12345;
        @(negedge clk);
        start = 1'b0;
        blow = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            rst_n = (n == 15) ? 1'b0 : 1'b1;
            if (done) blow++;
        end
        check("rstmid_nodone", 64'(blow),    64'd0);
        check("rstmid_busy",   64'(busy),    64'd0);
        check("rstmid_bcd",    64'(bcd_out), 64'd0);
        check("rstmid_blank",  64'(blank),   64'hFE);
        prev_bcd = 32'h0;
        conv(27'd1, -1, "one");

        // Randomized operands, biased toward the in-range region.
        for (int k = 0; k < 12; k++) begin
            rv = (k % 4 == 3) ? 27'($urandom_range(134217727, 0))
                              : 27'($urandom_range(99999999, 0));
            conv(rv, -1, $sformatf("rnd%0d", k));
        end

        // start held high: back-to-back conversions.
        @(negedge clk);
        start = 1'b1; bin_in = 27'd5;
        blow = 0;
        model(27'd5, eb, ebl, eo);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                pulses.push_back(c);
                check("held_bcd", 64'(bcd_out), 64'(eb));
            end
            if (pulses.size() == 1 && !busy) blow++;
        end
        start = 1'b0;
        check("held_npulse", 64'(pulses.size()), 64'd3);
        if (pulses.size() >= 2) check("held_gap1", 64'(pulses[1] - pulses[0]), 64'd29);
        if (pulses.size() >= 3) check("held_gap2", 64'(pulses[2] - pulses[1]), 64'd29);
        check("held_busylow", 64'(blow), 64'd1);
        repeat (35) @(negedge clk);
        check("held_flush", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
